// File: rtl/set_limit_bcd.sv
// BCD limit/setpoint register for the bottle-filling controller.
// Loaded directly or edited digit-by-digit; every write is digit- and range-clamped.
module set_limit_bcd #(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] LIMIT_MIN = 'h01,
    parameter logic [4*DIGITS-1:0] LIMIT_MAX = 'h99,
    parameter logic [4*DIGITS-1:0] RESET_VAL = 'h10,
    parameter int                  TIMEOUT   = 1000,
    localparam int                 W         = 4 * DIGITS,
    localparam int                 PW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN_work,
    input  logic          EN_set,
    input  logic          set,
    input  logic [W-1:0]  set_val,
    input  logic          btn_edit,
    input  logic          btn_inc,
    input  logic          btn_dec,
    input  logic          btn_next,
    input  logic          btn_commit,
    input  logic          btn_cancel,
    output logic [W-1:0]  limit,
    output logic [W-1:0]  edit_val,
    output logic [PW-1:0] edit_pos,
    output logic          editing,
    output logic          commit_pulse,
    output logic          abort_pulse,
    output logic          clamped
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, EDIT} state_t;

    state_t        state, state_n;
    logic [W-1:0]  limit_n, edit_val_n, load_val, commit_val;
    logic [PW-1:0] pos_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          clamped_n, commit_n, abort_n, ok, timed_out;
    logic [3:0]    cur_digit;

    function automatic logic [W-1:0] digit_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    // Digit-wise compare from the most significant digit; first differing digit decides.
    function automatic logic bcd_less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic lt, decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = a[4*i +: 4] < b[4*i +: 4];
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

    function automatic logic [W-1:0] range_clamp(input logic [W-1:0] v);
        if (bcd_less(v, LIMIT_MIN))      return LIMIT_MIN;
        else if (bcd_less(LIMIT_MAX, v)) return LIMIT_MAX;
        else                             return v;
    endfunction

    assign ok         = EN_work && !EN_set;
    assign load_val   = range_clamp(digit_clamp(set_val));
    assign commit_val = range_clamp(edit_val);
    assign timed_out  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    assign editing    = (state == EDIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            limit        <= RESET_VAL;
            edit_val     <= RESET_VAL;
            edit_pos     <= '0;
            cnt          <= '0;
            clamped      <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
        end else begin
            state        <= state_n;
            limit        <= limit_n;
            edit_val     <= edit_val_n;
            edit_pos     <= pos_n;
            cnt          <= cnt_n;
            clamped      <= clamped_n;
            commit_pulse <= commit_n;
            abort_pulse  <= abort_n;
        end
    end

    always_comb begin
        state_n    = state;
        limit_n    = limit;
        edit_val_n = edit_val;
        pos_n      = edit_pos;
        cnt_n      = cnt;
        clamped_n  = clamped;
        commit_n   = 1'b0;
        abort_n    = 1'b0;
        cur_digit  = 4'd0;
        case (state)
            IDLE: begin
                if (ok && set) begin
                    limit_n   = load_val;
                    clamped_n = (load_val != set_val);
                    commit_n  = 1'b1;
                end else if (ok && btn_edit) begin
                    state_n    = EDIT;
                    edit_val_n = limit;
                    pos_n      = '0;
                    cnt_n      = '0;
                end
            end
            EDIT: begin
                // Losing write permission discards the edit ahead of any key.
                if (!ok || btn_cancel) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end else if (btn_commit) begin
                    state_n   = IDLE;
                    limit_n   = commit_val;
                    clamped_n = (commit_val != edit_val);
                    commit_n  = 1'b1;
                end else if (btn_next) begin
                    pos_n = (edit_pos == PW'(DIGITS - 1)) ? '0 : edit_pos + 1'b1;
                    cnt_n = '0;
                end else if (btn_inc || btn_dec) begin
                    cnt_n = '0;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (edit_pos == PW'(i) && (btn_inc ^ btn_dec)) begin
                            cur_digit = edit_val[4*i +: 4];
                            if (btn_inc) cur_digit = (cur_digit >= 4'd9) ? 4'd0 : cur_digit + 4'd1;
                            else         cur_digit = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                            edit_val_n[4*i +: 4] = cur_digit;
                        end
                    end
                end else if (timed_out) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_set_limit_bcd.sv
// Scoreboard bench for set_limit_bcd: expected pulses are queued by the stimulus
// and checked by an independent monitor whenever commit_pulse/abort_pulse appears.
module tb_set_limit_bcd;

    localparam logic [7:0] K_SET = 8'h01, K_EDIT = 8'h02, K_INC = 8'h04, K_DEC = 8'h08,
                           K_NEXT = 8'h10, K_COMMIT = 8'h20, K_CANCEL = 8'h40;

    typedef struct packed {
        logic       is_commit;
        logic [7:0] lim;
        logic       clamped;
    } exp_t;

    logic       CLK, RST, EN_work, EN_set, set;
    logic [7:0] set_val;
    logic       btn_edit, btn_inc, btn_dec, btn_next, btn_commit, btn_cancel;
    logic [7:0] limit, edit_val, limit2, edit_val2;
    logic       edit_pos, editing, commit_pulse, abort_pulse, clamped;
    logic       edit_pos2, editing2, commit_pulse2, abort_pulse2, clamped2;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    set_limit_bcd #(.DIGITS(2), .LIMIT_MIN('h01), .LIMIT_MAX('h99), .RESET_VAL('h10), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .EN_work(EN_work), .EN_set(EN_set), .set(set), .set_val(set_val),
        .btn_edit(btn_edit), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next),
        .btn_commit(btn_commit), .btn_cancel(btn_cancel), .limit(limit), .edit_val(edit_val),
        .edit_pos(edit_pos), .editing(editing), .commit_pulse(commit_pulse),
        .abort_pulse(abort_pulse), .clamped(clamped)
    );

    // Narrow-range instance exercising the upper and lower range clamps on direct loads.
    set_limit_bcd #(.DIGITS(2), .LIMIT_MIN('h20), .LIMIT_MAX('h50), .RESET_VAL('h30), .TIMEOUT(0)) dut2 (
        .CLK(CLK), .RST(RST), .EN_work(EN_work), .EN_set(EN_set), .set(set), .set_val(set_val),
        .btn_edit(btn_edit), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next),
        .btn_commit(btn_commit), .btn_cancel(btn_cancel), .limit(limit2), .edit_val(edit_val2),
        .edit_pos(edit_pos2), .editing(editing2), .commit_pulse(commit_pulse2),
        .abort_pulse(abort_pulse2), .clamped(clamped2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] keys, input logic [7:0] sv);
        set        = keys[0];
        btn_edit   = keys[1];
        btn_inc    = keys[2];
        btn_dec    = keys[3];
        btn_next   = keys[4];
        btn_commit = keys[5];
        btn_cancel = keys[6];
        set_val    = sv;
        @(posedge CLK);
        #1;
        {set, btn_edit, btn_inc, btn_dec, btn_next, btn_commit, btn_cancel} = '0;
    endtask

    task automatic expectPulse(input logic is_commit, input logic [7:0] lim, input logic clmp);
        exp_t e;
        e.is_commit = is_commit;
        e.lim       = lim;
        e.clamped   = clmp;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RST && (commit_pulse || abort_pulse)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {commit_pulse, abort_pulse}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse_kind", {commit_pulse, abort_pulse}, mon_e.is_commit ? 2'b10 : 2'b01);
                checkOutput("pulse_limit", limit, mon_e.lim);
                checkOutput("pulse_clamped", clamped, mon_e.clamped);
                checkOutput("pulse_editing", editing, 1'b0);
            end
        end
    end

    initial begin
        RST = 1'b1; EN_work = 1'b1; EN_set = 1'b0;
        {set, btn_edit, btn_inc, btn_dec, btn_next, btn_commit, btn_cancel} = '0;
        set_val = '0;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        RST = 1'b0;
        checkOutput("rst_limit", limit, 'h10);
        checkOutput("rst_edit_val", edit_val, 'h10);
        checkOutput("rst_edit_pos", edit_pos, 0);
        checkOutput("rst_editing", editing, 0);
        checkOutput("rst_pulses", {commit_pulse, abort_pulse}, 0);
        checkOutput("rst_clamped", clamped, 0);
        checkOutput("rst_limit2", limit2, 'h30);

        // Direct load with an illegal digit.
        expectPulse(1, 'h97, 1);
        applyStimulus(K_SET, 'hA7);
        checkOutput("load_A7_limit", limit, 'h97);
        checkOutput("load_A7_clamped", clamped, 1);
        checkOutput("load_A7_pulse", commit_pulse, 1);
        checkOutput("load_A7_limit2", limit2, 'h50);
        checkOutput("load_A7_clamped2", clamped2, 1);
        applyStimulus(0, 0);
        checkOutput("load_A7_pulse_end", commit_pulse, 0);

        // Edit: inc x3 wraps digit 0, next, dec digit 1, commit.
        applyStimulus(K_EDIT, 0);
        checkOutput("edit_entry_editing", editing, 1);
        checkOutput("edit_entry_val", edit_val, 'h97);
        for (int i = 0; i < 3; i++) applyStimulus(K_INC, 0);
        checkOutput("inc_wrap_val", edit_val, 'h90);
        applyStimulus(K_NEXT, 0);
        checkOutput("next_pos", edit_pos, 1);
        applyStimulus(K_DEC, 0);
        checkOutput("dec_val", edit_val, 'h80);
        expectPulse(1, 'h80, 0);
        applyStimulus(K_COMMIT, 0);
        checkOutput("commit_limit", limit, 'h80);
        checkOutput("commit_clamped", clamped, 0);
        checkOutput("commit_limit2", limit2, 'h43);

        // Edit down to 00, commit clamps to LIMIT_MIN.
        applyStimulus(K_EDIT, 0);
        applyStimulus(K_NEXT, 0);
        for (int i = 0; i < 8; i++) applyStimulus(K_DEC, 0);
        checkOutput("edit_zero_val", edit_val, 'h00);
        applyStimulus(K_INC | K_DEC, 0);
        checkOutput("inc_dec_nochange", edit_val, 'h00);
        expectPulse(1, 'h01, 1);
        applyStimulus(K_COMMIT, 0);
        checkOutput("commit_min_limit", limit, 'h01);
        checkOutput("commit_min_clamped", clamped, 1);
        expectPulse(1, 'h01, 1);
        applyStimulus(K_SET, 'h00);
        checkOutput("load_00_limit", limit, 'h01);
        checkOutput("load_00_limit2", limit2, 'h20);
        expectPulse(1, 'h75, 0);
        applyStimulus(K_SET, 'h75);
        checkOutput("load_75_clamped", clamped, 0);
        checkOutput("load_75_limit2", limit2, 'h50);
        checkOutput("load_75_clamped2", clamped2, 1);

        // EN_set raised together with commit forces an abort.
        applyStimulus(K_EDIT, 0);
        applyStimulus(K_INC, 0);
        checkOutput("pre_abort_val", edit_val, 'h76);
        EN_set = 1'b1;
        expectPulse(0, 'h75, 0);
        applyStimulus(K_COMMIT, 0);
        checkOutput("forced_abort_pulse", abort_pulse, 1);
        checkOutput("forced_abort_editing", editing, 0);
        applyStimulus(K_SET, 'h33);
        checkOutput("locked_set_limit", limit, 'h75);
        checkOutput("locked_set_pulse", commit_pulse, 0);
        EN_set = 1'b0;

        // Timeout with no keys: abort 9 edges after the entry edge.
        expectPulse(0, 'h75, 0);
        applyStimulus(K_EDIT, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkOutput("timeout_not_yet", {editing, abort_pulse}, 2'b10);
        applyStimulus(0, 0);
        checkOutput("timeout_abort", {editing, abort_pulse}, 2'b01);

        // A key at cycle 5 restarts the idle count.
        expectPulse(0, 'h75, 0);
        applyStimulus(K_EDIT, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0);
        applyStimulus(K_NEXT, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkOutput("restart_not_yet", {editing, abort_pulse}, 2'b10);
        applyStimulus(0, 0);
        checkOutput("restart_abort", {editing, abort_pulse}, 2'b01);

        // set wins over btn_edit in the same cycle.
        expectPulse(1, 'h42, 0);
        applyStimulus(K_SET | K_EDIT, 'h42);
        checkOutput("set_wins_limit", limit, 'h42);
        checkOutput("set_wins_editing", editing, 0);

        // Reset in the middle of an edit.
        applyStimulus(K_EDIT, 0);
        applyStimulus(K_INC, 0);
        RST = 1'b1;
        applyStimulus(0, 0);
        checkOutput("midrst_limit", limit, 'h10);
        checkOutput("midrst_editing", editing, 0);
        checkOutput("midrst_pulses", {commit_pulse, abort_pulse}, 0);
        RST = 1'b0;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("midrst_hold_limit", limit, 'h10);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
